// File: rtl/axis_gain_limiter_if.sv
// AXI-Stream word channel: data, valid, ready and last.
// Valid/ready contract: a word moves on a rising clk edge where both valid
// and ready are 1. The master holds data/last stable while valid=1 and ready=0.
interface axis_gain_limiter_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/axis_gain_limiter.sv
// Frame-based gain and limiter stage for an audio AXI-Stream path.
// Each frame of NUM_CHANNELS samples is buffered, scaled by an unsigned Q2
// gain, saturated to full scale, optionally hard-clipped at +/-thresh and
// sent on. Counts saturated/clipped samples and flags malformed frames.
module axis_gain_limiter #(
    parameter int DATA_WIDTH   = 24,
    parameter int GAIN_WIDTH   = 8,
    parameter int NUM_CHANNELS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [GAIN_WIDTH+1:0]   gain,
    input  logic                    clip_en,
    input  logic [DATA_WIDTH-2:0]   thresh,
    input  logic                    clr_count,
    axis_gain_limiter_if.slave      s_axis,
    axis_gain_limiter_if.master     m_axis,
    output logic [15:0]             clip_count,
    output logic                    frame_err,
    output logic [1:0]              fsm_state
);
    localparam int DW = DATA_WIDTH;
    localparam int GW = GAIN_WIDTH;
    localparam int N  = NUM_CHANNELS;
    localparam int PW = DW + GW + 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        RECV = 2'd0,
        MUL  = 2'd1,
        CLIP = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t state, state_next;

    // Synchronizers for the asynchronous control inputs
    logic [GW+1:0] gain_meta, gain_sync;
    logic          clip_en_meta, clip_en_sync;
    logic [DW-2:0] thresh_meta, thresh_sync;

    // Per-frame copies of the synced controls
    logic [GW+1:0] gain_l;
    logic          clip_en_l;
    logic [DW-2:0] thresh_l;

    logic [DW-1:0]        samp      [N];
    logic signed [PW-1:0] prod      [N];
    logic signed [PW-1:0] prod_next [N];
    logic [DW-1:0]        res       [N];
    logic [DW-1:0]        res_next  [N];
    logic [CW-1:0]        n_hit;

    logic [IW-1:0] in_idx, out_idx, out_idx_inc;
    logic          s_ready, m_valid, m_last;
    logic [DW-1:0] m_data;
    logic          s_fire, in_close, m_fire, out_done;
    logic [16:0]   count_sum;

    assign s_axis.ready = s_ready;
    assign m_axis.valid = m_valid;
    assign m_axis.data  = m_data;
    assign m_axis.last  = m_last;
    assign fsm_state    = state;

    assign s_fire      = (state == RECV) && s_ready && s_axis.valid;
    assign in_close    = s_fire && (s_axis.last || (in_idx == LAST_IDX));
    assign m_fire      = (state == SEND) && m_valid && m_axis.ready;
    assign out_done    = m_fire && (out_idx == LAST_IDX);
    assign out_idx_inc = out_idx + IW'(1);

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            RECV:    if (in_close) state_next = MUL;
            MUL:     state_next = CLIP;
            CLIP:    state_next = SEND;
            SEND:    if (out_done) state_next = RECV;
            default: state_next = RECV;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RECV;
        else     state <= state_next;
    end

    // Two-flop synchronizers for gain, clip_en and thresh
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gain_meta    <= '0;
            gain_sync    <= '0;
            clip_en_meta <= 1'b0;
            clip_en_sync <= 1'b0;
            thresh_meta  <= '0;
            thresh_sync  <= '0;
        end else begin
            gain_meta    <= gain;
            gain_sync    <= gain_meta;
            clip_en_meta <= clip_en;
            clip_en_sync <= clip_en_meta;
            thresh_meta  <= thresh;
            thresh_sync  <= thresh_meta;
        end
    end

    // Frame capture: buffer words, zero-fill on early last, latch controls, track framing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_idx    <= '0;
            gain_l    <= '0;
            clip_en_l <= 1'b0;
            thresh_l  <= '0;
            frame_err <= 1'b0;
            for (int k = 0; k < N; k++) samp[k] <= '0;
        end else if (s_fire) begin
            if (in_idx == '0) begin
                gain_l    <= gain_sync;
                clip_en_l <= clip_en_sync;
                thresh_l  <= thresh_sync;
            end
            for (int k = 0; k < N; k++) begin
                if (IW'(k) == in_idx)
                    samp[k] <= s_axis.data;
                else if (s_axis.last && (IW'(k) > in_idx))
                    samp[k] <= '0;
            end
            if ((s_axis.last && (in_idx != LAST_IDX)) || (!s_axis.last && (in_idx == LAST_IDX)))
                frame_err <= 1'b1;
            in_idx <= in_close ? '0 : (in_idx + IW'(1));
        end
    end

    // Full-precision signed x unsigned product; both operands widened to PW bits
    always_comb begin
        for (int k = 0; k < N; k++) begin
            prod_next[k] = $signed({{(GW+2){samp[k][DW-1]}}, samp[k]})
                         * $signed({{DW{1'b0}}, gain_l});
        end
    end

    // MUL register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) prod[k] <= '0;
        end else if (state == MUL) begin
            for (int k = 0; k < N; k++) prod[k] <= prod_next[k];
        end
    end

    // Rescale, saturate to full scale, optional symmetric hard clip, count hits
    always_comb begin
        logic signed [PW-1:0] y;
        logic signed [PW-1:0] t_pos;
        logic signed [PW-1:0] t_neg;
        logic                 hit;
        n_hit = '0;
        y     = '0;
        hit   = 1'b0;
        t_pos = $signed({{(PW-DW+1){1'b0}}, thresh_l});
        t_neg = -t_pos;
        for (int k = 0; k < N; k++) begin
            y   = prod[k] >>> GW;
            hit = 1'b0;
            if (y > SAT_MAX) begin
                y   = SAT_MAX;
                hit = 1'b1;
            end else if (y < SAT_MIN) begin
                y   = SAT_MIN;
                hit = 1'b1;
            end
            if (clip_en_l) begin
                if (y > t_pos) begin
                    y   = t_pos;
                    hit = 1'b1;
                end else if (y < t_neg) begin
                    y   = t_neg;
                    hit = 1'b1;
                end
            end
            res_next[k] = y[DW-1:0];
            n_hit       = n_hit + CW'(hit);
        end
    end

    // CLIP register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) res[k] <= '0;
        end else if (state == CLIP) begin
            for (int k = 0; k < N; k++) res[k] <= res_next[k];
        end
    end

    assign count_sum = {1'b0, clip_count} + 17'(n_hit);

    // Saturating clip-event counter; clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                clip_count <= '0;
        else if (clr_count)     clip_count <= '0;
        else if (state == CLIP) clip_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end

    // Registered handshake and output word; data reads 0 whenever valid is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
            out_idx <= '0;
        end else begin
            s_ready <= (state_next == RECV);
            if (state == SEND) begin
                if (!m_valid) begin
                    m_valid <= 1'b1;
                    m_data  <= res[0];
                    m_last  <= (LAST_IDX == '0);
                    out_idx <= '0;
                end else if (m_axis.ready) begin
                    if (out_idx == LAST_IDX) begin
                        m_valid <= 1'b0;
                        m_data  <= '0;
                        m_last  <= 1'b0;
                        out_idx <= '0;
                    end else begin
                        m_data  <= res[out_idx_inc];
                        m_last  <= (out_idx_inc == LAST_IDX);
                        out_idx <= out_idx_inc;
                    end
                end
            end
        end
    end
endmodule

// File: doc/axis_gain_limiter.md
# axis_gain_limiter

Parametrised AXI-Stream gain and limiter stage for the Pmod I2S2 audio path. It sits between the I2S2 receive stream and the transmit stream. Each frame of NUM_CHANNELS samples is multiplied by a Q2 gain that can boost as well as attenuate. The result is saturated to full scale, optionally hard-clipped at a programmable symmetric threshold, and sent on. A saturating clip-event counter and a sticky framing-error flag are provided for diagnostics.

## Interface
- DATA_WIDTH, 24, sample width (signed two's complement)
- GAIN_WIDTH, 8, gain fraction bits; gain port is GAIN_WIDTH+2 bits, unsigned Q2.GAIN_WIDTH, unity = 1<<GAIN_WIDTH
- NUM_CHANNELS, 2, words per frame (>=1)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- gain  in  GAIN_WIDTH+2  gain, asynchronous (switches)
- clip_en  in  1  limiter enable, asynchronous (button)
- thresh  in  DATA_WIDTH-1  limiter magnitude T, unsigned, asynchronous
- clr_count  in  1  synchronous clear of clip_count
- s_axis_data  in  DATA_WIDTH  input sample
- s_axis_valid  in  1  input valid
- s_axis_ready  out  1  input ready
- s_axis_last  in  1  input last (final channel of frame)
- m_axis_data  out  DATA_WIDTH  output sample
- m_axis_valid  out  1  output valid
- m_axis_ready  in  1  output ready
- m_axis_last  out  1  output last
- clip_count  out  16  saturated or clipped samples, saturating at 0xFFFF
- frame_err  out  1  sticky; set on any framing violation, cleared only by rst

## Operation
- gain, clip_en and thresh each pass through a 2-flop synchronizer; synced values reset to 0.
- Synced values are latched once per frame, on the edge that accepts channel 0.
- State machine: RECV -> MUL -> CLIP -> SEND -> RECV.
- RECV:
  - s_axis_ready=1; word k of a frame is stored in buffer slot k.
  - The frame closes on the handshake with s_axis_last=1, or on word NUM_CHANNELS-1, whichever comes first.
  - Early last: remaining slots are zero-filled and frame_err is set.
  - Word NUM_CHANNELS-1 without last: the frame still closes and frame_err is set.
- MUL: per channel, p = sample * gain, full precision (DATA_WIDTH+GAIN_WIDTH+2 bits, signed × unsigned).
- CLIP:
  - y = p >>> GAIN_WIDTH (arithmetic shift, truncation toward -inf).
  - Saturate y to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - If the latched clip_en=1: y>T -> T; y<-T -> -T.
  - Each channel that was saturated or clipped counts once.
  - clip_count += that count, saturating at 0xFFFF. clr_count takes priority over a same-cycle increment.
- SEND:
  - Channels are output in order 0..NUM_CHANNELS-1.
  - m_axis_last=1 only on channel NUM_CHANNELS-1.
  - The word advances on each m_axis_valid && m_axis_ready.

## Timing
- Reset values (async, immediate): s_axis_ready=0, m_axis_valid=0, m_axis_last=0, m_axis_data=0, clip_count=0, frame_err=0, state=RECV, synchronizers=0.
- s_axis_ready rises on the first clk edge with rst low.
- Edge E accepts the closing input word: s_axis_ready=0 from E. The MUL register is written at E+1, the CLIP register at E+2, and m_axis_valid=1 from E+3. Latency is 3 cycles.
- While m_axis_valid=1 and m_axis_ready=0: m_axis_data and m_axis_last are held stable, with no limit on stall length.
- On the edge accepting the last output word: m_axis_valid=0 and s_axis_ready=1 in the same edge. The two interfaces are never ready/valid together.
- m_axis_data is registered (no combinational path from inputs); it reads 0 whenever m_axis_valid=0.
- s_axis_valid is ignored outside RECV.
- rst mid-frame or mid-SEND aborts the frame immediately. There is no partial output after release.
- Gain changes take effect on the next frame only, never mid-frame.

## Test plan
- Unity, defaults, gain=0x100, clip_en=0: frame {0x123456, 0xFEDCBA} -> output {0x123456, 0xFEDCBA}. last only on word 1; m_axis_valid rises exactly 3 cycles after the input-last handshake.
- Attenuate, gain=0x080: {0x123456, 0xFEDCBA} -> {0x091A2B, 0xFF6E5D} (truncation toward -inf). clip_count unchanged.
- Boost saturation, gain=0x200: {0x500000, 0xA00000} -> {0x7FFFFF, 0x800000}. clip_count increments by 2; clr_count pulse -> 0.
- Limiter, clip_en=1, thresh=0x100000, gain=0x100: {0x200000, 0xE00000} -> {0x100000, 0xF00000}. {0x080000, 0xF80000} passes unchanged.
- Backpressure: hold m_axis_ready=0 for 10 cycles during SEND -> data and last stable, s_axis_ready=0 throughout. The next frame is accepted only after the word-1 handshake.
- Framing and reset:
  - s_axis_last on word 0 -> output {scaled word0, 0x000000}, frame_err=1.
  - Assert rst during SEND -> all outputs at reset values at once; frame_err=0; the next frame processes normally.
